press_event_gen: RTL

//   Upstream stage of the 8-bit up counter: turns a raw, bouncy, asynchronous key/event

---
 rtl/press_event_gen.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/press_event_gen.sv
// Key debouncer feeding the counter enable: 2-flop sync, 4-state debounce FSM, single-cycle press/release pulses.
// Optional auto-repeat while held is enabled by defining PRESS_REPEAT_EN.
//
// state       | meaning
// IDLE        | debounced level low, waiting for key_s high
// PRESS_CHK   | key_s high, counting consecutive high samples
// PRESSED     | debounced level high, waiting for key_s low
// RELEASE_CHK | key_s low, counting consecutive low samples
module press_event_gen #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int REPEAT_CYCLES   = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic key_in,
  output logic press_pulse,
  output logic release_pulse,
  output logic level,
  output logic busy
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_SAT  = {CNT_W{1'b1}};

  if (DEBOUNCE_CYCLES < 2 || REPEAT_CYCLES < 2) begin : g_param_check
    $error("press_event_gen: DEBOUNCE_CYCLES and REPEAT_CYCLES must be >= 2");
  end

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    PRESS_CHK   = 2'd1,
    PRESSED     = 2'd2,
    RELEASE_CHK = 2'd3
  } state_t;

  state_t state, state_nxt;
  logic key_s1, key_s;
  logic [CNT_W-1:0] cnt, cnt_nxt, cnt_inc;
  logic level_nxt, press_nxt, release_nxt;

`ifdef PRESS_REPEAT_EN
  localparam int RPT_W = $clog2(REPEAT_CYCLES);
  localparam logic [RPT_W-1:0] RPT_LAST = RPT_W'(REPEAT_CYCLES - 1);
  logic [RPT_W-1:0] rpt, rpt_nxt;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      key_s1 <= 1'b0;
      key_s  <= 1'b0;
    end else begin
      key_s1 <= key_in;
      key_s  <= key_s1;
    end
  end

  assign cnt_inc = (cnt == CNT_SAT) ? cnt : cnt + CNT_W'(1);

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    level_nxt   = level;
    press_nxt   = 1'b0;
    release_nxt = 1'b0;
`ifdef PRESS_REPEAT_EN
    rpt_nxt     = rpt;
`endif
    case (state)
      IDLE: begin
`ifdef PRESS_REPEAT_EN
        rpt_nxt = '0;
`endif
        if (key_s) begin
          state_nxt = PRESS_CHK;
          cnt_nxt   = CNT_W'(1);
        end else begin
          cnt_nxt = '0;
        end
      end
      PRESS_CHK: begin
        if (!key_s) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else if (cnt == CNT_LAST) begin
          state_nxt = PRESSED;
          level_nxt = 1'b1;
          press_nxt = 1'b1;
          cnt_nxt   = '0;
`ifdef PRESS_REPEAT_EN
          rpt_nxt   = '0;
`endif
        end else begin
          cnt_nxt = cnt_inc;
        end
      end
      PRESSED: begin
        if (!key_s) begin
          state_nxt = RELEASE_CHK;
          cnt_nxt   = CNT_W'(1);
        end
`ifdef PRESS_REPEAT_EN
        // Repeat only while the key stays down; leaving for RELEASE_CHK freezes rpt.
        else if (rpt == RPT_LAST) begin
          press_nxt = 1'b1;
          rpt_nxt   = '0;
        end else begin
          rpt_nxt = rpt + RPT_W'(1);
        end
`endif
      end
      RELEASE_CHK: begin
        if (key_s) begin
          state_nxt = PRESSED;
          cnt_nxt   = '0;
        end else if (cnt == CNT_LAST) begin
          state_nxt   = IDLE;
          level_nxt   = 1'b0;
          release_nxt = 1'b1;
          cnt_nxt     = '0;
        end else begin
          cnt_nxt = cnt_inc;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
        level_nxt = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      cnt           <= '0;
      level         <= 1'b0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      busy          <= 1'b0;
    end else begin
      state         <= state_nxt;
      cnt           <= cnt_nxt;
      level         <= level_nxt;
      press_pulse   <= press_nxt;
      release_pulse <= release_nxt;
      busy          <= (state_nxt == PRESS_CHK) || (state_nxt == RELEASE_CHK);
    end
  end

`ifdef PRESS_REPEAT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) rpt <= '0;
    else        rpt <= rpt_nxt;
  end
`endif

endmodule
